// File: rtl/fifo_umbral_param.sv
// Synchronous FIFO with live almost-full / almost-empty thresholds.
// Popped words leave through a registered output one cycle after the pop.
// The error flag is sticky and records both overflow and underflow.
module fifo_umbral_param #(
  parameter int data_width    = 6,
  parameter int address_width = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_enable,
  input  logic [data_width-1:0]    data_in,
  input  logic                     pop,
  input  logic [address_width:0]   umbral_alto,
  input  logic [address_width:0]   umbral_bajo,
  output logic [data_width-1:0]    data_out,
  output logic                     valid_out,
  output logic [address_width:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     error
);

  localparam int DEPTH = 2 ** address_width;
  // Occupancy value that means "full", sized to match count.
  localparam logic [address_width:0] DEPTH_C = {1'b1, {address_width{1'b0}}};

  logic [data_width-1:0]    mem_q [DEPTH];
  logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [address_width:0]   count_q, count_d;
  logic [data_width-1:0]    data_out_q, data_out_d;
  logic                     valid_out_q, valid_out_d;
  logic                     error_q, error_d;

  logic pop_ok;
  logic push_ok;

  // Accept decisions and next-state computation.
  always_comb begin
    // A pop needs a stored word; a push needs room, or a pop freeing a slot.
    // A push into an empty FIFO never feeds a same-cycle pop.
    pop_ok      = pop && (count_q != '0);
    push_ok     = wr_enable && ((count_q != DEPTH_C) || pop_ok);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    error_d     = error_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end

    // Rejected push or pop on empty latches the error until reset.
    if ((wr_enable && !push_ok) || (pop && !pop_ok)) begin
      error_d = 1'b1;
    end
  end

  // Control and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
    end
  end

  // Storage array; contents survive reset, only writes are blocked during it.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign count        = count_q;
  assign error        = error_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= umbral_alto);
  assign almost_empty = (count_q <= umbral_bajo);

endmodule

// File: doc/fifo_umbral_param.md
FIFO_UMBRAL_PARAM -- requirements
Module: fifo_umbral_param

Interface
REQ-001 The block SHALL have parameter data_width, default 6, giving the width of each stored word.
REQ-002 The block SHALL have parameter address_width, default 2, with depth DEPTH = 2**address_width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-005 The block SHALL have port wr_enable, input, 1 bit, push request.
REQ-006 The block SHALL have port data_in, input, data_width bits, word to push.
REQ-007 The block SHALL have port pop, input, 1 bit, pop request.
REQ-008 The block SHALL have port umbral_alto, input, address_width+1 bits, almost-full threshold.
REQ-009 The block SHALL have port umbral_bajo, input, address_width+1 bits, almost-empty threshold.
REQ-010 The block SHALL have port data_out, output, data_width bits, registered popped word.
REQ-011 The block SHALL have port valid_out, output, 1 bit, data_out holds a word popped in the previous cycle.
REQ-012 The block SHALL have port count, output, address_width+1 bits, current occupancy 0..DEPTH.
REQ-013 The block SHALL have ports full, empty, almost_full, almost_empty, error, each output, 1 bit, status flags.

Function
REQ-014 Storage SHALL be DEPTH words with write and read pointers of address_width bits, wrapping from DEPTH-1 to 0.
REQ-015 A push SHALL be accepted when wr_enable=1 and (count<DEPTH or an accepted pop occurs in the same cycle).
REQ-016 A pop SHALL be accepted when pop=1 and count>0; a same-cycle push never satisfies a pop on an empty FIFO (no bypass).
REQ-017 count SHALL be +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-018 On an accepted pop, data_out SHALL take the word at the read pointer and valid_out SHALL be 1 on the next cycle (latency 1).
REQ-019 When no pop is accepted, valid_out SHALL be 0 the next cycle and data_out SHALL hold its last value.
REQ-020 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), derived from the registered count.
REQ-021 almost_full SHALL equal (count>=umbral_alto); almost_empty SHALL equal (count<=umbral_bajo); thresholds are used live, not latched.
REQ-022 Overflow (wr_enable=1 and push rejected) SHALL drop data_in, leave memory and pointers unchanged, and set error.
REQ-023 Underflow (pop=1 and count==0) SHALL leave pointers unchanged, keep valid_out 0, and set error.
REQ-024 error SHALL be sticky: once set, it stays 1 until reset.
REQ-025 Words SHALL leave in strict push order with no loss or duplication across pointer wrap-around.
REQ-026 Changing parameters SHALL require no RTL edits other than the parameter values.

Reset
REQ-027 While reset=1 at a rising edge, the block SHALL clear pointers, count=0, data_out=0, valid_out=0 and error=0, and SHALL ignore wr_enable and pop.
REQ-028 After reset, empty=1, full=0, almost_full=(0>=umbral_alto), almost_empty=1 for umbral_bajo>=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; the first pop after release with count==0 is an underflow.
REQ-030 Memory contents need not be cleared by reset.

Verification (defaults: data_width=6, address_width=2, DEPTH=4)
REQ-031 Reset, push 01,02,03,04 -> count=4, full=1, error=0; push 05 -> dropped, error=1, count=4.
REQ-032 Fill 21..24, pop 4 cycles -> data_out 21,22,23,24 each one cycle after its pop with valid_out=1, then empty=1.
REQ-033 Full FIFO, push 25 and pop same cycle -> pop returns oldest word, 25 stored, count stays 4, error=0.
REQ-034 Empty FIFO, push 11 and pop same cycle -> error=1, valid_out=0, count=1; next pop returns 11.
REQ-035 umbral_alto=3, umbral_bajo=1: push 0..4 words -> almost_empty=1 at count 0,1; almost_full=1 at count 3,4.
REQ-036 Ten push/pop cycles wrapping pointers, then reset mid-stream -> count=0, valid_out=0, error=0; order preserved before reset.
